// File: rtl/cpu_clock_ctrl_if.sv
// cpu_clock_ctrl_if: signal bundle between the speed-control logic and the CPU clock generator.
//   cpu_speed     requested speed code (4 bit, clamped inside the block)
//   contend       ULA contention active
//   mem_wait      memory not ready, freezes the phase counter
//   cpu_ce_p      one-clk CPU rising-edge enable
//   cpu_ce_n      one-clk CPU falling-edge enable
//   cur_speed     speed code currently applied
//   speed_busy    speed change pending
//   speed_changed one-clk pulse when a new speed takes effect
// master drives the requests; slave is the clock controller.
interface cpu_clock_ctrl_if;
    logic [3:0] cpu_speed;
    logic       contend;
    logic       mem_wait;
    logic       cpu_ce_p;
    logic       cpu_ce_n;
    logic [1:0] cur_speed;
    logic       speed_busy;
    logic       speed_changed;

    modport master (
        output cpu_speed, contend, mem_wait,
        input  cpu_ce_p, cpu_ce_n, cur_speed, speed_busy, speed_changed
    );

    modport slave (
        input  cpu_speed, contend, mem_wait,
        output cpu_ce_p, cpu_ce_n, cur_speed, speed_busy, speed_changed
    );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: generates CPU rising/falling clock enables from a 2x master clock, with a
// selectable CPU period of 16/8/4/2 clk (speed codes 0..3). Speed changes and contention changes
// only take effect at the 15->0 boundary of the 4-bit phase counter so no CPU half-period is cut.
// Ports:
//   clk    master clock (2x the fastest CPU rate)
//   rst_n  asynchronous active-low reset
//   bus    cpu_clock_ctrl_if.slave (speed request, contention, wait, enables and status)
module cpu_clock_ctrl #(
    parameter logic [1:0] MAX_SPEED = 2'd3
) (
    input logic              clk,
    input logic              rst_n,
    cpu_clock_ctrl_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StPending} state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] cur_q, cur_d;
    logic [1:0] target_q, target_d;
    logic       contend_q, contend_d;
    logic       ce_p_q, ce_p_d;
    logic       ce_n_q, ce_n_d;
    logic       changed_q, changed_d;

    logic [1:0] tgt;
    logic [1:0] eff;
    logic [3:0] mask;
    logic [3:0] half;
    logic       frame_end;

    always_comb begin
        tgt = (bus.cpu_speed > {2'b00, MAX_SPEED}) ? MAX_SPEED : bus.cpu_speed[1:0];
        // Contention uses the frame-registered copy so eff only moves at a frame boundary.
        eff = contend_q ? 2'd0 : cur_q;
        // (16 >> eff) - 1 is the same as 15 >> eff.
        mask = 4'hF >> eff;
        half = 4'h8 >> eff;
        frame_end = (cnt_q == 4'hF) && !bus.mem_wait;
    end

    always_comb begin
        cnt_d     = bus.mem_wait ? cnt_q : cnt_q + 4'd1;
        ce_p_d    = !bus.mem_wait && ((cnt_q & mask) == 4'd0);
        ce_n_d    = !bus.mem_wait && ((cnt_q & mask) == half);
        contend_d = frame_end ? bus.contend : contend_q;

        state_d   = state_q;
        cur_d     = cur_q;
        target_d  = target_q;
        changed_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tgt != cur_q) begin
                    state_d  = StPending;
                    target_d = tgt;
                end
            end
            StPending: begin
                target_d = tgt;
                if (tgt == cur_q) begin
                    // Request withdrawn before it was applied.
                    state_d = StIdle;
                end else if (frame_end) begin
                    cur_d     = target_q;
                    changed_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            cur_q     <= 2'd0;
            target_q  <= 2'd0;
            contend_q <= 1'b0;
            ce_p_q    <= 1'b0;
            ce_n_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_q     <= cur_d;
            target_q  <= target_d;
            contend_q <= contend_d;
            ce_p_q    <= ce_p_d;
            ce_n_q    <= ce_n_d;
            changed_q <= changed_d;
        end
    end

    assign bus.cpu_ce_p      = ce_p_q;
    assign bus.cpu_ce_n      = ce_n_q;
    assign bus.cur_speed     = cur_q;
    assign bus.speed_busy    = (state_q == StPending);
    assign bus.speed_changed = changed_q;

endmodule
